// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, data requester and unified-memory signals
//   that pass through mem_port_arbiter.
//   Modports:
//     slave  - the arbiter: takes requests and mem_rdata; drives readies,
//              responses, memory address/write controls and busy.
//     master - the environment: the requesters plus the memory model.
//   Signals:
//     if_req_valid/if_req_ready/if_addr/if_flush  fetch request side
//     if_resp_valid/if_resp_data                  fetch response
//     d_req_valid/d_req_ready/d_addr/d_we/d_wdata data request side
//     d_resp_valid/d_resp_data                    data response
//     mem_addr/mem_we/mem_wdata/mem_rdata         single memory port
//     busy                                        access in progress
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req_valid, if_addr, if_flush,
    input  d_req_valid, d_addr, d_we, d_wdata,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output if_req_valid, if_addr, if_flush,
    output d_req_valid, d_addr, d_we, d_wdata,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory (async read, posedge write) between the
//   instruction-fetch and data requesters. Each accepted request holds the
//   port for MEM_LATENCY cycles and produces exactly one response pulse.
//   Data has priority; after STARVE_LIMIT consecutive data grants with a
//   fetch waiting, the fetch is forced through. if_flush cancels the
//   response of an accepted/in-flight fetch without shortening the access.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    mem_port_arbiter_if.slave (requests, responses, memory port)
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [STARVE_W-1:0] r_starve;
  logic [31:0]         r_addr;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic                r_owner_d;
  logic                r_kill;
  logic                r_if_resp_valid;
  logic [31:0]         r_if_resp_data;
  logic                r_d_resp_valid;
  logic [31:0]         r_d_resp_data;

  logic w_idle;
  logic w_starved;
  logic w_grant_d;
  logic w_grant_f;
  logic w_accept_d;
  logic w_accept_f;
  logic w_last;

  assign w_idle    = (r_state == ST_IDLE) && !reset;
  assign w_starved = (r_starve == STARVE_W'(STARVE_LIMIT)) && bus.if_req_valid;
  assign w_grant_d = bus.d_req_valid && !w_starved;
  assign w_grant_f = bus.if_req_valid && !w_grant_d;

  // Readies are only offered in IDLE, so a grant is always an accept.
  assign bus.d_req_ready  = w_idle && w_grant_d;
  assign bus.if_req_ready = w_idle && w_grant_f;
  assign w_accept_d = bus.d_req_valid && bus.d_req_ready;
  assign w_accept_f = bus.if_req_valid && bus.if_req_ready;

  // Final cycle of an access: write happens and read data is captured.
  assign w_last = (r_state == ST_ACCESS) && (r_cnt == '0);

  assign bus.busy          = (r_state == ST_ACCESS) && !reset;
  assign bus.mem_we        = w_last && r_we && !reset;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.if_resp_valid = r_if_resp_valid && !reset;
  assign bus.if_resp_data  = r_if_resp_data;
  assign bus.d_resp_valid  = r_d_resp_valid && !reset;
  assign bus.d_resp_data   = r_d_resp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_starve        <= '0;
      r_addr          <= '0;
      r_we            <= 1'b0;
      r_wdata         <= '0;
      r_owner_d       <= 1'b0;
      r_kill          <= 1'b0;
      r_if_resp_valid <= 1'b0;
      r_if_resp_data  <= '0;
      r_d_resp_valid  <= 1'b0;
      r_d_resp_data   <= '0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_d_resp_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept_d || w_accept_f) begin
            r_state   <= ST_ACCESS;
            r_cnt     <= CNT_W'(MEM_LATENCY - 1);
            r_addr    <= w_accept_d ? bus.d_addr : bus.if_addr;
            r_we      <= w_accept_d && bus.d_we;
            r_wdata   <= w_accept_d ? bus.d_wdata : 32'h0;
            r_owner_d <= w_accept_d;
            r_kill    <= w_accept_f && bus.if_flush;
            // Starvation only accumulates while fetch is actually waiting.
            if (w_accept_f || !bus.if_req_valid) begin
              r_starve <= '0;
            end else if (r_starve != STARVE_W'(STARVE_LIMIT)) begin
              r_starve <= r_starve + STARVE_W'(1);
            end
          end
        end
        ST_ACCESS: begin
          if (!r_owner_d && bus.if_flush) begin
            r_kill <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_kill  <= 1'b0;
            if (r_owner_d) begin
              r_d_resp_valid <= 1'b1;
              r_d_resp_data  <= r_we ? 32'h0 : bus.mem_rdata;
            end else if (!(r_kill || bus.if_flush)) begin
              // A flush in the final cycle still cancels this response.
              r_if_resp_valid <= 1'b1;
              r_if_resp_data  <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4)
//   with a 256-word memory model; word i initialised to 0xA0000000+i.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_LATENCY (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [0:255];
  bit          mem_init_done;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  int tests_run;
  int tests_failed;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b1;
    bus.if_req_valid = 1'b1;
    bus.d_req_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      settle();
      tests_run++; if (bus.if_req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_if_ready got=%0h exp=0", bus.if_req_ready); end
      tests_run++; if (bus.d_req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_d_ready got=%0h exp=0", bus.d_req_ready); end
      tests_run++; if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_we got=%0h/%0h exp=0/0", bus.busy, bus.mem_we); end
      tests_run++; if (bus.if_resp_valid !== 1'b0 || bus.d_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_resp got=%0h/%0h exp=0/0", bus.if_resp_valid, bus.d_resp_valid); end
    end
    tests_run++; if (bus.mem_addr !== 32'h0 || bus.d_resp_data !== 32'h0) begin tests_failed++; $display("FAIL rst_regs got=%h/%h exp=0/0", bus.mem_addr, bus.d_resp_data); end
    step();
    reset = 1'b0;
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    settle();
    $display("[TB] reset: outputs cleared");
  endtask

  task automatic test_fetch();
    step();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h10;
    settle();
    tests_run++; if (bus.if_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin tests_failed++; $display("FAIL t1_ready got=%0h/%0h exp=1/0", bus.if_req_ready, bus.d_req_ready); end
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) bus.if_req_valid = 1'b0;
      settle();
      tests_run++; if (bus.if_resp_valid !== (k == 3)) begin tests_failed++; $display("FAIL t1_resp_valid k=%0d got=%0h exp=%0h", k, bus.if_resp_valid, (k == 3)); end
      tests_run++; if (bus.busy !== (k <= 2)) begin tests_failed++; $display("FAIL t1_busy k=%0d got=%0h exp=%0h", k, bus.busy, (k <= 2)); end
      if (k == 1) begin
        tests_run++; if (bus.mem_addr !== 32'h10) begin tests_failed++; $display("FAIL t1_mem_addr got=%h exp=00000010", bus.mem_addr); end
      end
    end
    tests_run++; if (bus.if_resp_data !== 32'hA000_0004) begin tests_failed++; $display("FAIL t1_data got=%h exp=a0000004", bus.if_resp_data); end
    $display("[TB] T1 fetch 0x10 -> %h", bus.if_resp_data);
  endtask

  task automatic test_priority();
    step();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h40;
    bus.d_we         = 1'b0;
    settle();
    tests_run++; if (bus.d_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0) begin tests_failed++; $display("FAIL t2_grant got d=%0h f=%0h exp d=1 f=0", bus.d_req_ready, bus.if_req_ready); end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) bus.d_req_valid  = 1'b0;
      if (k == 4) bus.if_req_valid = 1'b0;
      settle();
      tests_run++; if (bus.if_req_ready !== (k == 3)) begin tests_failed++; $display("FAIL t2_if_ready k=%0d got=%0h exp=%0h", k, bus.if_req_ready, (k == 3)); end
      tests_run++; if (bus.d_resp_valid !== (k == 3)) begin tests_failed++; $display("FAIL t2_d_resp k=%0d got=%0h exp=%0h", k, bus.d_resp_valid, (k == 3)); end
      tests_run++; if (bus.if_resp_valid !== (k == 6)) begin tests_failed++; $display("FAIL t2_if_resp k=%0d got=%0h exp=%0h", k, bus.if_resp_valid, (k == 6)); end
      if (k == 3) begin
        tests_run++; if (bus.d_resp_data !== 32'hA000_0010) begin tests_failed++; $display("FAIL t2_d_data got=%h exp=a0000010", bus.d_resp_data); end
      end
      if (k == 6) begin
        tests_run++; if (bus.if_resp_data !== 32'hA000_0000) begin tests_failed++; $display("FAIL t2_if_data got=%h exp=a0000000", bus.if_resp_data); end
      end
    end
    $display("[TB] T2 load 0x40 -> %h, fetch 0x0 -> %h", bus.d_resp_data, bus.if_resp_data);
  endtask

  task automatic test_starvation();
    logic [5:0] exp_d;
    exp_d = 6'b101111;
    step();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h4;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h80;
    bus.d_we         = 1'b0;
    for (int g = 0; g < 6; g++) begin
      if (g > 0) repeat (3) step();
      settle();
      tests_run++; if (bus.d_req_ready !== exp_d[g]) begin tests_failed++; $display("FAIL t3_d_grant g=%0d got=%0h exp=%0h", g, bus.d_req_ready, exp_d[g]); end
      tests_run++; if (bus.if_req_ready !== !exp_d[g]) begin tests_failed++; $display("FAIL t3_f_grant g=%0d got=%0h exp=%0h", g, bus.if_req_ready, !exp_d[g]); end
    end
    step();
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    step();
    step();
    settle();
    tests_run++; if (bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 32'hA000_0020) begin tests_failed++; $display("FAIL t3_last_resp got=%0h/%h exp=1/a0000020", bus.d_resp_valid, bus.d_resp_data); end
    $display("[TB] T3 grants d,d,d,d,f,d checked");
  endtask

  task automatic test_store();
    int we_cnt;
    we_cnt = 0;
    step();
    bus.d_req_valid = 1'b1;
    bus.d_addr      = 32'h20;
    bus.d_we        = 1'b1;
    bus.d_wdata     = 32'hDEAD_BEEF;
    settle();
    tests_run++; if (bus.d_req_ready !== 1'b1) begin tests_failed++; $display("FAIL t4_ready got=%0h exp=1", bus.d_req_ready); end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin bus.d_req_valid = 1'b0; bus.d_we = 1'b0; end
      if (k == 3) begin bus.if_req_valid = 1'b1; bus.if_addr = 32'h20; end
      if (k == 4) bus.if_req_valid = 1'b0;
      settle();
      if (bus.mem_we === 1'b1) we_cnt++;
      if (k == 2) begin
        tests_run++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL t4_write got we=%0h a=%h d=%h exp we=1 a=00000020 d=deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      end
      if (k == 3) begin
        tests_run++; if (bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 32'h0) begin tests_failed++; $display("FAIL t4_ack got=%0h/%h exp=1/00000000", bus.d_resp_valid, bus.d_resp_data); end
        tests_run++; if (bus.if_req_ready !== 1'b1) begin tests_failed++; $display("FAIL t4_f_ready got=%0h exp=1", bus.if_req_ready); end
      end
      if (k == 6) begin
        tests_run++; if (bus.if_resp_valid !== 1'b1 || bus.if_resp_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL t4_readback got=%0h/%h exp=1/deadbeef", bus.if_resp_valid, bus.if_resp_data); end
      end
    end
    tests_run++; if (we_cnt !== 1) begin tests_failed++; $display("FAIL t4_we_count got=%0d exp=1", we_cnt); end
    $display("[TB] T4 store 0x20 then fetch -> %h", bus.if_resp_data);
  endtask

  task automatic test_flush();
    int  busy_cnt;
    logic resp_seen;
    busy_cnt  = 0;
    resp_seen = 1'b0;
    step();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h8;
    settle();
    tests_run++; if (bus.if_req_ready !== 1'b1) begin tests_failed++; $display("FAIL t5_ready got=%0h exp=1", bus.if_req_ready); end
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin bus.if_req_valid = 1'b0; bus.if_flush = 1'b1; end
      if (k == 2) bus.if_flush = 1'b0;
      if (k == 3) begin bus.if_req_valid = 1'b1; bus.if_addr = 32'hC; end
      settle();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.if_resp_valid !== 1'b0) resp_seen = 1'b1;
    end
    tests_run++; if (bus.if_req_ready !== 1'b1) begin tests_failed++; $display("FAIL t5_next_ready got=%0h exp=1", bus.if_req_ready); end
    tests_run++; if (busy_cnt !== 2) begin tests_failed++; $display("FAIL t5_busy_cycles got=%0d exp=2", busy_cnt); end
    tests_run++; if (resp_seen !== 1'b0) begin tests_failed++; $display("FAIL t5_suppressed got=%0h exp=0", resp_seen); end
    tests_run++; if (bus.if_resp_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL t5_data_held got=%h exp=deadbeef", bus.if_resp_data); end
    for (int k = 4; k <= 6; k++) begin
      step();
      if (k == 4) bus.if_req_valid = 1'b0;
      settle();
      tests_run++; if (bus.if_resp_valid !== (k == 6)) begin tests_failed++; $display("FAIL t5_resp k=%0d got=%0h exp=%0h", k, bus.if_resp_valid, (k == 6)); end
    end
    tests_run++; if (bus.if_resp_data !== 32'hA000_0003) begin tests_failed++; $display("FAIL t5_next_data got=%h exp=a0000003", bus.if_resp_data); end
    $display("[TB] T5 flushed fetch 0x8, next fetch 0xC -> %h", bus.if_resp_data);
  endtask

  task automatic test_reset_mid();
    step();
    bus.d_req_valid = 1'b1;
    bus.d_addr      = 32'h30;
    bus.d_we        = 1'b1;
    bus.d_wdata     = 32'h1234_5678;
    settle();
    tests_run++; if (bus.d_req_ready !== 1'b1) begin tests_failed++; $display("FAIL t6_ready got=%0h exp=1", bus.d_req_ready); end
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin reset = 1'b1; bus.if_req_valid = 1'b1; end
      settle();
      tests_run++; if (bus.d_req_ready !== 1'b0 || bus.if_req_ready !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_ready k=%0d got=%0h/%0h exp=0/0", k, bus.d_req_ready, bus.if_req_ready); end
      tests_run++; if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_we_busy k=%0d got=%0h/%0h exp=0/0", k, bus.mem_we, bus.busy); end
    end
    for (int k = 4; k <= 7; k++) begin
      step();
      if (k == 4) begin
        reset = 1'b0;
        bus.d_req_valid  = 1'b0;
        bus.d_we         = 1'b0;
        bus.if_req_valid = 1'b0;
      end
      settle();
      tests_run++; if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t6_after_we_busy k=%0d got=%0h/%0h exp=0/0", k, bus.mem_we, bus.busy); end
      tests_run++; if (bus.d_resp_valid !== 1'b0 || bus.if_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL t6_after_resp k=%0d got=%0h/%0h exp=0/0", k, bus.d_resp_valid, bus.if_resp_valid); end
    end
    tests_run++; if (mem[12] !== 32'hA000_000C) begin tests_failed++; $display("FAIL t6_mem_untouched got=%h exp=a000000c", mem[12]); end
    tests_run++; if (bus.d_resp_data !== 32'h0 || bus.if_resp_data !== 32'h0) begin tests_failed++; $display("FAIL t6_data_cleared got=%h/%h exp=0/0", bus.d_resp_data, bus.if_resp_data); end
    $display("[TB] T6 store 0x30 aborted by reset, mem word 12 = %h", mem[12]);
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.if_addr      = 32'h0;
    bus.if_flush     = 1'b0;
    bus.d_req_valid  = 1'b0;
    bus.d_addr       = 32'h0;
    bus.d_we         = 1'b0;
    bus.d_wdata      = 32'h0;

    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
